// File: rtl/opl3_pkg.sv
// Shared OPL3 constants: DAC sample width and the I2S transmitter defaults.
package opl3_pkg;

  localparam int DAC_OUTPUT_WIDTH  = 24;
  localparam int I2S_SLOT_WIDTH    = 32;
  localparam int I2S_BCLK_HALF_DIV = 4;
  localparam int I2S_CNT_WIDTH     = 8;
  localparam int I2S_DIV_WIDTH     = 8;

  function automatic logic [I2S_CNT_WIDTH-1:0] sat_inc(input logic [I2S_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + I2S_CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: registered bclk plus a one-cycle strobe in the cycle
// whose clock edge drives bclk from 1 to 0.
module i2s_bclk_gen
  import opl3_pkg::*;
#(
  parameter int BCLK_HALF_DIV = I2S_BCLK_HALF_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic bclk,
  output logic fall_evt
);

  logic [I2S_DIV_WIDTH-1:0] div_q, div_d;
  logic                     bclk_q, bclk_d;
  logic                     wrap;

  always_comb begin
    wrap     = (div_q == I2S_DIV_WIDTH'(BCLK_HALF_DIV - 1));
    div_d    = wrap ? '0 : div_q + I2S_DIV_WIDTH'(1);
    bclk_d   = wrap ? ~bclk_q : bclk_q;
    fall_evt = wrap & bclk_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk = bclk_q;

endmodule

// File: rtl/i2s_tx.sv
// Stereo I2S transmitter: buffers one pending sample pair, frames it with one
// bit of delay after each lrclk edge, and counts underruns/overruns.
module i2s_tx
  import opl3_pkg::*;
#(
  parameter int BCLK_HALF_DIV = I2S_BCLK_HALF_DIV,
  parameter int SLOT_WIDTH    = I2S_SLOT_WIDTH
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               sample_valid,
  input  logic signed [DAC_OUTPUT_WIDTH-1:0] sample_l,
  input  logic signed [DAC_OUTPUT_WIDTH-1:0] sample_r,
  output logic                               i2s_bclk,
  output logic                               i2s_lrclk,
  output logic                               i2s_sdata,
  output logic [I2S_CNT_WIDTH-1:0]           underrun_cnt,
  output logic [I2S_CNT_WIDTH-1:0]           overrun_cnt
);

  localparam int FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int PAD        = SLOT_WIDTH - DAC_OUTPUT_WIDTH;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  logic                        fall_evt;
  logic                        load;
  logic [CNT_W-1:0]            bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]            bit_sel;
  logic                        lrclk_q, lrclk_d;
  logic                        sdata_q, sdata_d;
  logic [DAC_OUTPUT_WIDTH-1:0] buf_l_q, buf_l_d;
  logic [DAC_OUTPUT_WIDTH-1:0] buf_r_q, buf_r_d;
  logic                        pending_q, pending_d;
  logic [FRAME_BITS-1:0]       frame_q, frame_d;
  logic [I2S_CNT_WIDTH-1:0]    under_q, under_d;
  logic [I2S_CNT_WIDTH-1:0]    over_q, over_d;

  i2s_bclk_gen #(
    .BCLK_HALF_DIV(BCLK_HALF_DIV)
  ) u_bclk_gen (
    .clk     (clk),
    .reset   (reset),
    .bclk    (i2s_bclk),
    .fall_evt(fall_evt)
  );

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    lrclk_d   = lrclk_q;
    sdata_d   = sdata_q;
    buf_l_d   = buf_l_q;
    buf_r_d   = buf_r_q;
    pending_d = pending_q;
    frame_d   = frame_q;
    under_d   = under_q;
    over_d    = over_q;

    load      = fall_evt && (bit_cnt_q == LAST_BIT);

    if (fall_evt) begin
      bit_cnt_d = load ? '0 : bit_cnt_q + CNT_W'(1);
    end
    bit_sel = CNT_W'(FRAME_BITS - int'(bit_cnt_d));

    if (fall_evt) begin
      lrclk_d = (bit_cnt_d >= CNT_W'(SLOT_WIDTH));
      if (load) begin
        // Without a fresh sample the buffer still holds the last pair, so it is re-sent.
        frame_d = {buf_l_q, {PAD{1'b0}}, buf_r_q, {PAD{1'b0}}};
        sdata_d = 1'b0;
        if (!pending_q) under_d = sat_inc(under_q);
      end else begin
        sdata_d = frame_q[bit_sel];
      end
    end

    // A strobe coinciding with a load becomes the next pending pair, not an overrun.
    if (sample_valid) begin
      buf_l_d   = sample_l;
      buf_r_d   = sample_r;
      pending_d = 1'b1;
      if (pending_q && !load) over_d = sat_inc(over_q);
    end else if (load) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q <= LAST_BIT;
      lrclk_q   <= 1'b0;
      sdata_q   <= 1'b0;
      buf_l_q   <= '0;
      buf_r_q   <= '0;
      pending_q <= 1'b0;
      frame_q   <= '0;
      under_q   <= '0;
      over_q    <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      lrclk_q   <= lrclk_d;
      sdata_q   <= sdata_d;
      buf_l_q   <= buf_l_d;
      buf_r_q   <= buf_r_d;
      pending_q <= pending_d;
      frame_q   <= frame_d;
      under_q   <= under_d;
      over_q    <= over_d;
    end
  end

  assign i2s_lrclk    = lrclk_q;
  assign i2s_sdata    = sdata_q;
  assign underrun_cnt = under_q;
  assign overrun_cnt  = over_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: a serial monitor rebuilds each frame and checks
// it against expected sample pairs queued by the directed stimulus.
module tb_i2s_tx;
  import opl3_pkg::*;

  localparam int FB = 2 * I2S_SLOT_WIDTH;

  typedef struct packed {
    logic [23:0] l;
    logic [23:0] r;
  } frame_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [23:0] sample_l, sample_r;
  logic        i2s_bclk, i2s_lrclk, i2s_sdata;
  logic [7:0]  underrun_cnt, overrun_cnt;

  logic        sat_reset;
  logic        sat_bclk, sat_lrclk, sat_sdata;
  logic [7:0]  sat_under, sat_over;
  int          sat_cyc;

  frame_t      sb[$];
  int          total = 0;
  int          bad   = 0;

  int          mon_k = FB - 1;
  int          mon_cyc = 0;
  int          frames_done = 0;
  bit          mon_fall = 1'b0;
  bit          have_fall = 1'b0;
  logic        prev_bclk = 1'b0, prev_lr = 1'b0, prev_sd = 1'b0;
  logic [FB-1:0] rx = '0;

  always #5 clk = ~clk;

  i2s_tx #(
    .BCLK_HALF_DIV(I2S_BCLK_HALF_DIV),
    .SLOT_WIDTH   (I2S_SLOT_WIDTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_valid(sample_valid),
    .sample_l    (sample_l),
    .sample_r    (sample_r),
    .i2s_bclk    (i2s_bclk),
    .i2s_lrclk   (i2s_lrclk),
    .i2s_sdata   (i2s_sdata),
    .underrun_cnt(underrun_cnt),
    .overrun_cnt (overrun_cnt)
  );

  // Small, fast instance used only to drive the underrun counter into saturation.
  i2s_tx #(
    .BCLK_HALF_DIV(2),
    .SLOT_WIDTH   (25)
  ) sat_dut (
    .clk         (clk),
    .reset       (sat_reset),
    .sample_valid(1'b0),
    .sample_l    (24'h0),
    .sample_r    (24'h0),
    .i2s_bclk    (sat_bclk),
    .i2s_lrclk   (sat_lrclk),
    .i2s_sdata   (sat_sdata),
    .underrun_cnt(sat_under),
    .overrun_cnt (sat_over)
  );

  always @(posedge clk) begin
    if (sat_reset) sat_cyc <= 0;
    else           sat_cyc <= sat_cyc + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Serial monitor: tracks bit position from bclk falling edges, checks timing
  // and lrclk, and compares each completed frame with the scoreboard head.
  always @(negedge clk) begin
    frame_t e;
    mon_fall = 1'b0;
    if (reset) begin
      mon_k       = FB - 1;
      mon_cyc     = 0;
      frames_done = 0;
      have_fall   = 1'b0;
      prev_bclk   = 1'b0;
      prev_lr     = 1'b0;
      prev_sd     = 1'b0;
    end else begin
      mon_cyc++;
      if (prev_bclk && !i2s_bclk) begin
        mon_k    = (mon_k == FB - 1) ? 0 : mon_k + 1;
        mon_fall = 1'b1;
        if (have_fall) checkOutput("bclk_period", mon_cyc, 2 * I2S_BCLK_HALF_DIV);
        mon_cyc   = 0;
        have_fall = 1'b1;
        checkOutput("lrclk", i2s_lrclk, (mon_k >= I2S_SLOT_WIDTH) ? 1 : 0);
        if (mon_k == 0) begin
          checkOutput("sdata_k0", i2s_sdata, 0);
          rx = '0;
        end else begin
          rx[FB - mon_k] = i2s_sdata;
        end
        if (mon_k == FB - 1) begin
          frames_done++;
          if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("frame_left", rx[63:40], e.l);
            checkOutput("frame_right", rx[31:8], e.r);
            checkOutput("frame_pad", {rx[39:32], rx[7:1]}, 0);
          end
        end
      end else begin
        if (!prev_bclk && i2s_bclk && have_fall)
          checkOutput("bclk_high", mon_cyc, I2S_BCLK_HALF_DIV);
        checkOutput("lrclk_stable", i2s_lrclk, prev_lr);
        checkOutput("sdata_stable", i2s_sdata, prev_sd);
      end
      prev_bclk = i2s_bclk;
      prev_lr   = i2s_lrclk;
      prev_sd   = i2s_sdata;
    end
  end

  task automatic expectFrame(input logic [23:0] l, input logic [23:0] r);
    frame_t f;
    f.l = l;
    f.r = r;
    sb.push_back(f);
  endtask

  task automatic applyStimulus(input logic [23:0] l, input logic [23:0] r, input bit push);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_l     = l;
    sample_r     = r;
    if (push) expectFrame(l, r);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Every expected frame must have been seen before the next reset.
  task automatic doReset();
    checkOutput("sb_drain", sb.size(), 0);
    sb.delete();
    @(negedge clk);
    reset        = 1'b1;
    sample_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_bclk", i2s_bclk, 0);
    checkOutput("rst_lrclk", i2s_lrclk, 0);
    checkOutput("rst_sdata", i2s_sdata, 0);
    checkOutput("rst_underrun", underrun_cnt, 0);
    checkOutput("rst_overrun", overrun_cnt, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic waitBit(input int kk);
    bit found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(posedge clk);
      if (mon_fall && mon_k == kk) found = 1'b1;
    end
    checkOutput($sformatf("wait_bit_%0d", kk), found, 1);
  endtask

  task automatic waitFrames(input int target);
    bit found = 1'b0;
    for (int i = 0; i < 700 * (target + 1) && !found; i++) begin
      @(posedge clk);
      if (frames_done >= target) found = 1'b1;
    end
    checkOutput($sformatf("wait_frames_%0d", target), found, 1);
    @(negedge clk);
  endtask

  task automatic waitSat(input int n);
    for (int i = 0; i < 70000 && sat_cyc < n; i++) @(negedge clk);
    checkOutput("sat_wait", (sat_cyc >= n) ? 1 : 0, 1);
  endtask

  initial begin
    reset        = 1'b1;
    sat_reset    = 1'b1;
    sample_valid = 1'b0;
    sample_l     = '0;
    sample_r     = '0;

    // Idle after reset: three all-zero frames, each one an underrun.
    doReset();
    sat_reset = 1'b0;
    expectFrame(24'h0, 24'h0);
    expectFrame(24'h0, 24'h0);
    expectFrame(24'h0, 24'h0);
    waitFrames(3);
    checkOutput("idle_underrun", underrun_cnt, 3);
    checkOutput("idle_overrun", overrun_cnt, 0);

    // One strobe ahead of the first frame: extreme MSB/LSB patterns.
    doReset();
    applyStimulus(24'h800001, 24'h7FFFFE, 1'b1);
    waitFrames(1);
    checkOutput("single_underrun", underrun_cnt, 0);

    // A single sample is held and repeated across four frames.
    doReset();
    applyStimulus(24'h000001, 24'h000000, 1'b1);
    expectFrame(24'h000001, 24'h000000);
    expectFrame(24'h000001, 24'h000000);
    expectFrame(24'h000001, 24'h000000);
    waitFrames(4);
    checkOutput("hold_underrun", underrun_cnt, 3);

    // Three strobes inside one frame: the last one wins, two overruns.
    doReset();
    expectFrame(24'h0, 24'h0);
    waitBit(10);
    applyStimulus(24'hA0A0A0, 24'h0A0A0A, 1'b0);
    applyStimulus(24'hB1B1B1, 24'h1B1B1B, 1'b0);
    applyStimulus(24'hC2C2C2, 24'h2C2C2C, 1'b1);
    waitFrames(2);
    checkOutput("burst_overrun", overrun_cnt, 2);
    checkOutput("burst_underrun", underrun_cnt, 1);

    // Strobe D lands in the exact load cycle while E is pending.
    doReset();
    expectFrame(24'h0, 24'h0);
    waitBit(5);
    applyStimulus(24'hE5E5E5, 24'h5E5E5E, 1'b1);
    waitBit(FB - 1);
    repeat (2 * I2S_BCLK_HALF_DIV - 2) @(negedge clk);
    applyStimulus(24'hD4D4D4, 24'h4D4D4D, 1'b1);
    waitFrames(3);
    checkOutput("loadcycle_overrun", overrun_cnt, 0);
    checkOutput("loadcycle_underrun", underrun_cnt, 1);

    // Reset in the middle of the left slot truncates the frame.
    doReset();
    applyStimulus(24'hFFFFFF, 24'hFFFFFF, 1'b0);
    waitBit(10);
    repeat (I2S_BCLK_HALF_DIV) @(negedge clk);
    checkOutput("pre_rst_bclk", i2s_bclk, 1);
    checkOutput("pre_rst_sdata", i2s_sdata, 1);
    checkOutput("pre_rst_lrclk", i2s_lrclk, 0);
    doReset();
    expectFrame(24'h0, 24'h0);
    waitFrames(1);
    checkOutput("post_rst_underrun", underrun_cnt, 1);

    // Saturation instance: 101 loads by cycle 20100, over 300 by cycle 60100.
    waitSat(20100);
    checkOutput("sat_mid", sat_under, 101);
    waitSat(60100);
    checkOutput("sat_hold", sat_under, 255);
    checkOutput("sat_overrun", sat_over, 0);

    checkOutput("sb_final", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter BCLK_HALF_DIV, default I2S_BCLK_HALF_DIV (4): clk cycles per half period of i2s_bclk; legal range 2..255.
REQ-002 Parameter SLOT_WIDTH, default I2S_SLOT_WIDTH (32): bclk periods per channel slot; SHALL exceed DAC_OUTPUT_WIDTH.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  sole clock; the DAC clock domain.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sample_valid  input  1  single-cycle strobe; sample_l and sample_r are valid in that cycle.
REQ-007 sample_l  input  DAC_OUTPUT_WIDTH  signed left sample.
REQ-008 sample_r  input  DAC_OUTPUT_WIDTH  signed right sample.
REQ-009 i2s_bclk  output  1  bit clock, registered.
REQ-010 i2s_lrclk  output  1  word select; 0 = left, 1 = right; registered.
REQ-011 i2s_sdata  output  1  serial data, MSB first, two's complement; registered.
REQ-012 underrun_cnt  output  8  saturating count of frames that started with no new sample.
REQ-013 overrun_cnt  output  8  saturating count of samples overwritten before use.

Function
REQ-014 The divider SHALL count 0..BCLK_HALF_DIV-1 and toggle i2s_bclk on wrap: period is 2*BCLK_HALF_DIV clk cycles with a 50% duty cycle.
REQ-015 bit_cnt (0..2*SLOT_WIDTH-1) SHALL advance, wrapping to 0, on each falling-edge event (the cycle that drives i2s_bclk 1->0); i2s_lrclk and i2s_sdata SHALL update only on those events.
REQ-016 At the event where bit_cnt becomes k, i2s_lrclk SHALL be (k >= SLOT_WIDTH).
REQ-017 frame_sr (2*SLOT_WIDTH bits) SHALL be {left sample, zero pad, right sample, zero pad}, each sample left-justified in its slot.
REQ-018 At the event where bit_cnt becomes 0, frame_sr SHALL load from the pending buffer and i2s_sdata SHALL be 0.
REQ-019 At the event where bit_cnt becomes k (1..2*SLOT_WIDTH-1), i2s_sdata SHALL be frame_sr[2*SLOT_WIDTH-k]; this gives standard I2S one-bit delay after each lrclk edge.
REQ-020 The pending buffer SHALL capture sample_l/sample_r when sample_valid is high and set pending_valid.
REQ-021 A frame load SHALL clear pending_valid, except that a simultaneous sample_valid leaves it set.
REQ-022 Load with pending_valid = 0: re-send the last buffer contents (hold) and increment underrun_cnt.
REQ-023 sample_valid while pending_valid = 1 with no load in the same cycle: the newest sample wins and overrun_cnt increments.
REQ-024 sample_valid in the same clk cycle as a load: frame_sr takes the old buffer contents and the new sample becomes pending; this is not an overrun.
REQ-025 Both counters SHALL saturate at 255 and never wrap.

Reset
REQ-026 On reset: i2s_bclk=0, i2s_lrclk=0, i2s_sdata=0; divider=0; bit_cnt=2*SLOT_WIDTH-1, so the first falling event loads a frame; buffer=0; pending_valid=0; frame_sr=0; both counters=0.
REQ-027 Reset asserted mid-frame SHALL take effect on the next clk edge and truncate the frame; no partial state survives.

Structure
REQ-028 I2S_SLOT_WIDTH, I2S_BCLK_HALF_DIV and I2S counter width constants SHALL live in opl3_pkg next to DAC_OUTPUT_WIDTH.
REQ-029 The divider and edge-event generation SHALL be sub-module i2s_bclk_gen, which outputs bclk plus one-cycle fall_evt; all framing stays in i2s_tx.
REQ-030 The block SHALL consume the sample_valid/sample_l/sample_r outputs of the upstream DAC-prep stage directly; it adds no CDC logic.

Verification
REQ-031 Reset then idle 3 frames with defaults: bclk period 8 clk, 64 bclks per lrclk period, sdata all 0, underrun_cnt=3.
REQ-032 One strobe, L=24'h800001 and R=24'h7FFFFE, before a frame start: left slot bits 1..24 read 1000_0000_..._0001, right slot reads 0111_..._1110; pad bits are 0.
REQ-033 Strobe L=24'h000001 only once, then 4 frames: all 4 frames repeat it and underrun_cnt=3.
REQ-034 Three strobes (A, B, C) within one frame: the next frame carries C and overrun_cnt=2.
REQ-035 Strobe in the exact load cycle with new D while old E is pending: the current frame carries E, the next carries D, and overrun_cnt is unchanged.
REQ-036 Force 300 underruns: underrun_cnt holds at 255; reset mid-left-slot: outputs 0 the next cycle and a fresh frame follows.
